// File: rtl/light_bbox.sv
// Scans a WIDTH x HEIGHT gray frame from RAM and reports the bounding box of bright pixels.
// Optional pixel counting and a MIN_PIXELS qualifier are enabled by defining LIGHT_BBOX_COUNT_EN.
module light_bbox #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned RD_LAT = 2
`ifdef LIGHT_BBOX_COUNT_EN
    ,
    parameter int unsigned MIN_PIXELS = 4
`endif
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iSTART,
    input  logic [7:0]  iTHRESH,
    output logic [16:0] oADDR,
    input  logic [7:0]  iDATA,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oVALID,
    output logic [8:0]  oXMIN,
    output logic [8:0]  oXMAX,
    output logic [7:0]  oYMIN,
    output logic [7:0]  oYMAX
`ifdef LIGHT_BBOX_COUNT_EN
    ,
    output logic [16:0] oCOUNT
`endif
);

    localparam int unsigned NPIX       = WIDTH * HEIGHT;
    localparam logic [16:0] LAST_ADDR  = 17'(NPIX - 1);
    localparam logic [8:0]  LAST_X     = 9'(WIDTH - 1);
    localparam logic [2:0]  LAST_DRAIN = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

    state_e      state_q, state_d;
    logic        accept, scan;
    logic [16:0] addr_q;
    logic [8:0]  x_q;
    logic [7:0]  y_q;
    logic [2:0]  drain_q;
    logic [7:0]  thresh_q;

    // Coordinates travel alongside the read so they line up with iDATA.
    logic        pv_q [RD_LAT];
    logic [8:0]  px_q [RD_LAT];
    logic [7:0]  py_q [RD_LAT];

    logic        bright, found;
    logic [8:0]  xmin_q, xmax_q;
    logic [7:0]  ymin_q, ymax_q;

    logic        res_valid;
    logic [8:0]  res_xmin, res_xmax;
    logic [7:0]  res_ymin, res_ymax;
    logic        out_valid_q;
    logic [8:0]  out_xmin_q, out_xmax_q;
    logic [7:0]  out_ymin_q, out_ymax_q;

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (iSTART) state_d = StScan;
            StScan:  if (addr_q == LAST_ADDR) state_d = StDrain;
            StDrain: if (drain_q == LAST_DRAIN) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        oBUSY  = (state_q != StIdle);
        oDONE  = (state_q == StDone);
        scan   = (state_q == StScan);
        accept = (state_q == StIdle) && iSTART;
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            addr_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            drain_q  <= '0;
            thresh_q <= '0;
        end else begin
            if (accept) thresh_q <= iTHRESH;
            if (scan) begin
                if (addr_q == LAST_ADDR) begin
                    addr_q <= '0;
                    x_q    <= '0;
                    y_q    <= '0;
                end else begin
                    addr_q <= addr_q + 17'd1;
                    if (x_q == LAST_X) begin
                        x_q <= '0;
                        y_q <= y_q + 8'd1;
                    end else begin
                        x_q <= x_q + 9'd1;
                    end
                end
            end
            if (state_q == StDrain) drain_q <= drain_q + 3'd1;
            else                    drain_q <= '0;
        end
    end

    assign oADDR = addr_q;

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i] <= 1'b0;
                px_q[i] <= '0;
                py_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= scan;
            px_q[0] <= x_q;
            py_q[0] <= y_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                px_q[i] <= px_q[i-1];
                py_q[i] <= py_q[i-1];
            end
        end
    end

    assign bright = pv_q[RD_LAT-1] && (iDATA > thresh_q);

`ifdef LIGHT_BBOX_COUNT_EN
    localparam logic [16:0] CNT_SAT = 17'd76800;
    logic [16:0] cnt_q, out_cnt_q;

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET)                          cnt_q <= '0;
        else if (accept)                     cnt_q <= '0;
        else if (bright && cnt_q != CNT_SAT) cnt_q <= cnt_q + 17'd1;
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET)                 out_cnt_q <= '0;
        else if (state_q == StDone) out_cnt_q <= cnt_q;
    end

    assign found     = (cnt_q != '0);
    assign res_valid = (cnt_q >= 17'(MIN_PIXELS));
    assign oCOUNT    = (state_q == StDone) ? cnt_q : out_cnt_q;
`else
    logic hit_q;

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET)      hit_q <= 1'b0;
        else if (accept) hit_q <= 1'b0;
        else if (bright) hit_q <= 1'b1;
    end

    assign found     = hit_q;
    assign res_valid = hit_q;
`endif

    // First bright pixel seeds the box; later ones only widen it.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            xmin_q <= '0;
            xmax_q <= '0;
            ymin_q <= '0;
            ymax_q <= '0;
        end else if (accept) begin
            xmin_q <= '0;
            xmax_q <= '0;
            ymin_q <= '0;
            ymax_q <= '0;
        end else if (bright) begin
            if (!found || px_q[RD_LAT-1] < xmin_q) xmin_q <= px_q[RD_LAT-1];
            if (!found || px_q[RD_LAT-1] > xmax_q) xmax_q <= px_q[RD_LAT-1];
            if (!found || py_q[RD_LAT-1] < ymin_q) ymin_q <= py_q[RD_LAT-1];
            if (!found || py_q[RD_LAT-1] > ymax_q) ymax_q <= py_q[RD_LAT-1];
        end
    end

    always_comb begin
        res_xmin = res_valid ? xmin_q : '0;
        res_xmax = res_valid ? xmax_q : '0;
        res_ymin = res_valid ? ymin_q : '0;
        res_ymax = res_valid ? ymax_q : '0;
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            out_valid_q <= 1'b0;
            out_xmin_q  <= '0;
            out_xmax_q  <= '0;
            out_ymin_q  <= '0;
            out_ymax_q  <= '0;
        end else if (state_q == StDone) begin
            out_valid_q <= res_valid;
            out_xmin_q  <= res_xmin;
            out_xmax_q  <= res_xmax;
            out_ymin_q  <= res_ymin;
            out_ymax_q  <= res_ymax;
        end
    end

    // Results appear during the DONE cycle itself and are held afterwards.
    always_comb begin
        if (state_q == StDone) begin
            oVALID = res_valid;
            oXMIN  = res_xmin;
            oXMAX  = res_xmax;
            oYMIN  = res_ymin;
            oYMAX  = res_ymax;
        end else begin
            oVALID = out_valid_q;
            oXMIN  = out_xmin_q;
            oXMAX  = out_xmax_q;
            oYMIN  = out_ymin_q;
            oYMAX  = out_ymax_q;
        end
    end

endmodule

// File: tb/tb_light_bbox.sv
// Bench for light_bbox: three instances (read latency 2, 1, 4) share one small frame memory.
module tb_light_bbox;

    localparam int TW = 40;
    localparam int TH = 36;
    localparam int NP = TW * TH;

    logic        clk, rst, start;
    logic [7:0]  thresh;
    logic [16:0] addr [3];
    logic [7:0]  data [3];
    logic        busy [3];
    logic        done [3];
    logic        valid [3];
    logic [8:0]  xmin [3];
    logic [8:0]  xmax [3];
    logic [7:0]  ymin [3];
    logic [7:0]  ymax [3];
`ifdef LIGHT_BBOX_COUNT_EN
    logic [16:0] count [3];
`endif

    logic [7:0] frame [NP];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        logic [7:0] rp [4];
        always @(posedge clk) begin
            rp[0] <= (addr[g] < 17'(NP)) ? frame[addr[g]] : 8'd0;
            for (int i = 1; i < 4; i++) rp[i] <= rp[i-1];
        end
        assign data[g] = rp[L-1];

        light_bbox #(.WIDTH(TW), .HEIGHT(TH), .RD_LAT(L)) u_dut (
            .iCLK    (clk),
            .iRESET  (rst),
            .iSTART  (start),
            .iTHRESH (thresh),
            .oADDR   (addr[g]),
            .iDATA   (data[g]),
            .oBUSY   (busy[g]),
            .oDONE   (done[g]),
            .oVALID  (valid[g]),
            .oXMIN   (xmin[g]),
            .oXMAX   (xmax[g]),
            .oYMIN   (ymin[g]),
            .oYMAX   (ymax[g])
`ifdef LIGHT_BBOX_COUNT_EN
            ,
            .oCOUNT  (count[g])
`endif
        );
    end

    function automatic int lat_of(input int d);
        return NP + ((d == 0) ? 2 : ((d == 1) ? 1 : 4)) + 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected results for the current scan
    int e_cnt, e_valid, e_xmin, e_xmax, e_ymin, e_ymax;

    task automatic set_expect(input int cnt, input int x0, input int x1, input int y0,
                              input int y1);
        e_cnt = cnt;
`ifdef LIGHT_BBOX_COUNT_EN
        e_valid = (cnt >= 4) ? 1 : 0;
`else
        e_valid = (cnt > 0) ? 1 : 0;
`endif
        e_xmin = e_valid ? x0 : 0;
        e_xmax = e_valid ? x1 : 0;
        e_ymin = e_valid ? y0 : 0;
        e_ymax = e_valid ? y1 : 0;
    endtask

    // Reference: plain scan over the image array
    task automatic model(input int th);
        int cnt, x0, x1, y0, y1;
        cnt = 0; x0 = TW; x1 = -1; y0 = TH; y1 = -1;
        for (int y = 0; y < TH; y++)
            for (int x = 0; x < TW; x++)
                if (int'(frame[y*TW+x]) > th) begin
                    cnt++;
                    if (x < x0) x0 = x;
                    if (x > x1) x1 = x;
                    if (y < y0) y0 = y;
                    if (y > y1) y1 = y;
                end
        if (cnt > 76800) cnt = 76800;
        set_expect(cnt, x0, x1, y0, y1);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < NP; i++) frame[i] = 8'd0;
    endtask

    task automatic put(input int x, input int y, input int v);
        if (x >= 0) frame[y*TW+x] = 8'(v);
    endtask

    int cap_lat [3];
    int got [3];
    int cap_valid [3], cap_xmin [3], cap_xmax [3], cap_ymin [3], cap_ymax [3], cap_cnt [3];
    int addr_err, busy_a1, busy_a2, addr_a2, after_valid, after_xmin, after_ymax;

    task automatic do_scan(input logic [7:0] th, input bit hold);
        int k;
        @(negedge clk);
        start = 1'b1;
        thresh = th;
        for (int d = 0; d < 3; d++) begin got[d] = 0; cap_lat[d] = 0; end
        addr_err = 0; busy_a1 = -1; busy_a2 = -1; addr_a2 = -1;
        after_valid = -1; after_xmin = -1; after_ymax = -1;
        k = 0;
        while (k < NP + 40) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            k++;
            if (k <= NP && addr[0] != 17'(k - 1)) addr_err++;
            for (int d = 0; d < 3; d++)
                if (done[d]) begin
                    got[d]++;
                    cap_lat[d] = k;
                    cap_valid[d] = int'(valid[d]);
                    cap_xmin[d] = int'(xmin[d]);
                    cap_xmax[d] = int'(xmax[d]);
                    cap_ymin[d] = int'(ymin[d]);
                    cap_ymax[d] = int'(ymax[d]);
`ifdef LIGHT_BBOX_COUNT_EN
                    cap_cnt[d] = int'(count[d]);
`endif
                end
            if (got[0] != 0 && k == cap_lat[0] + 1) begin
                busy_a1 = int'(busy[0]);
                after_valid = int'(valid[0]);
                after_xmin = int'(xmin[0]);
                after_ymax = int'(ymax[0]);
            end
            if (got[0] != 0 && k == cap_lat[0] + 2) begin
                busy_a2 = int'(busy[0]);
                addr_a2 = int'(addr[0]);
            end
            if (got[0] != 0 && got[1] != 0 && got[2] != 0 && k >= cap_lat[0] + 2) break;
        end
        start = 1'b0;
    endtask

    task automatic check_scan(input string name, input bit hold);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s.d%0d.done_pulses", name, d), got[d], 1);
            chk($sformatf("%s.d%0d.latency", name, d), cap_lat[d], lat_of(d));
            chk($sformatf("%s.d%0d.valid", name, d), cap_valid[d], e_valid);
            chk($sformatf("%s.d%0d.xmin", name, d), cap_xmin[d], e_xmin);
            chk($sformatf("%s.d%0d.xmax", name, d), cap_xmax[d], e_xmax);
            chk($sformatf("%s.d%0d.ymin", name, d), cap_ymin[d], e_ymin);
            chk($sformatf("%s.d%0d.ymax", name, d), cap_ymax[d], e_ymax);
`ifdef LIGHT_BBOX_COUNT_EN
            chk($sformatf("%s.d%0d.count", name, d), cap_cnt[d], e_cnt);
`endif
        end
        chk({name, ".addr_seq_errs"}, addr_err, 0);
        chk({name, ".busy_after_done"}, busy_a1, 0);
        chk({name, ".hold_valid"}, after_valid, e_valid);
        chk({name, ".hold_xmin"}, after_xmin, e_xmin);
        chk({name, ".hold_ymax"}, after_ymax, e_ymax);
        chk({name, ".restart_busy"}, busy_a2, hold ? 1 : 0);
        if (hold) chk({name, ".restart_addr"}, addr_a2, 0);
    endtask

    task automatic check_zero(input string name);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s.d%0d.addr", name, d), int'(addr[d]), 0);
            chk($sformatf("%s.d%0d.busy", name, d), int'(busy[d]), 0);
            chk($sformatf("%s.d%0d.done", name, d), int'(done[d]), 0);
            chk($sformatf("%s.d%0d.valid", name, d), int'(valid[d]), 0);
            chk($sformatf("%s.d%0d.box", name, d),
                int'(xmin[d]) + int'(xmax[d]) + int'(ymin[d]) + int'(ymax[d]), 0);
        end
    endtask

    typedef struct {
        int x0, y0, v0, x1, y1, v1, x2, y2, v2;
        int th, cnt, xmin, xmax, ymin, ymax;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int k, stray, th;
        vecs[0] = '{-1, 0, 0, -1, 0, 0, -1, 0, 0, 10, 0, 0, 0, 0, 0};
        vecs[1] = '{17, 33, 200, -1, 0, 0, -1, 0, 0, 100, 1, 17, 17, 33, 33};
        vecs[2] = '{0, 0, 255, 39, 35, 255, 20, 10, 254, 254, 2, 0, 39, 0, 35};
        vecs[3] = '{5, 5, 100, -1, 0, 0, -1, 0, 0, 100, 0, 0, 0, 0, 0};
        vecs[4] = '{3, 30, 50, 30, 3, 50, 12, 12, 49, 49, 2, 3, 30, 3, 30};

        rst = 1'b1; start = 1'b0; thresh = 8'd0;
        clear_frame();
        @(negedge clk);
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            clear_frame();
            put(vecs[i].x0, vecs[i].y0, vecs[i].v0);
            put(vecs[i].x1, vecs[i].y1, vecs[i].v1);
            put(vecs[i].x2, vecs[i].y2, vecs[i].v2);
            set_expect(vecs[i].cnt, vecs[i].xmin, vecs[i].xmax, vecs[i].ymin, vecs[i].ymax);
            do_scan(8'(vecs[i].th), 1'b0);
            check_scan($sformatf("vec%0d", i), 1'b0);
        end

        for (int r = 0; r < 3; r++) begin
            th = int'($urandom_range(20, 200));
            for (int p = 0; p < NP; p++) frame[p] = 8'($urandom_range(0, th));
            for (int b = 0; b < 1 + r * 2; b++)
                put(int'($urandom_range(0, TW - 1)), int'($urandom_range(0, TH - 1)),
                    int'($urandom_range(th + 1, 255)));
            model(th);
            do_scan(8'(th), 1'b0);
            check_scan($sformatf("rand%0d", r), 1'b0);
        end

        // Reset in the middle of a scan
        @(negedge clk);
        start = 1'b1; thresh = 8'd100;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (addr[0] != 17'd700 && k < NP) begin @(negedge clk); k++; end
        chk("midscan.reached", int'(addr[0]), 700);
        rst = 1'b1;
        #1;
        check_zero("midscan_reset");
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) if (done[d] || busy[d]) stray++;
        end
        chk("midscan.no_done_after_reset", stray, 0);
        clear_frame();
        put(17, 33, 200);
        put(2, 7, 101);
        model(100);
        do_scan(8'd100, 1'b0);
        check_scan("after_reset", 1'b0);

        // iSTART held high for the whole scan
        clear_frame();
        put(39, 0, 180);
        model(90);
        do_scan(8'd90, 1'b1);
        check_scan("held_start", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/light_bbox.md
LIGHT_BBOX -- requirements
Module: light_bbox

Interface
REQ-001 Parameter WIDTH, default 320, SHALL set the pixels per line of the downsampled gray frame.
REQ-002 Parameter HEIGHT, default 240, SHALL set the lines per frame.
REQ-003 Parameter RD_LAT, default 2, SHALL set the frame-RAM read latency in cycles, with a legal range of 1 to 4.
REQ-004 iCLK  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 iRESET  in  1  SHALL be an asynchronous, active-high reset.
REQ-006 iSTART  in  1  SHALL be a single-cycle request to scan one frame; it SHALL be ignored while oBUSY=1.
REQ-007 iTHRESH  in  8  SHALL be the brightness threshold, latched on an accepted iSTART.
REQ-008 oADDR  out  17  SHALL be the frame-RAM read address, row-major, addr = y*WIDTH + x.
REQ-009 iDATA  in  8  SHALL be the gray pixel read data, valid RD_LAT cycles after its oADDR.
REQ-010 oBUSY  out  1  SHALL be high from the cycle after an accepted start until oDONE.
REQ-011 oDONE  out  1  SHALL be a one-cycle pulse indicating that the result outputs have been updated.
REQ-012 oVALID  out  1  SHALL indicate that at least one qualifying bright pixel was found in the last scan.
REQ-013 oXMIN, oXMAX  out  9 each  SHALL carry the bounding-box column extent of bright pixels.
REQ-014 oYMIN, oYMAX  out  8 each  SHALL carry the bounding-box row extent of bright pixels.

Function
REQ-015 The FSM SHALL have the states IDLE, SCAN, DRAIN and DONE, with the transitions IDLE->SCAN on iSTART, SCAN->DRAIN after address WIDTH*HEIGHT-1 is issued, DRAIN->DONE after RD_LAT cycles, and DONE->IDLE unconditionally.
REQ-016 In SCAN, oADDR SHALL start at 0 and increment by 1 every cycle, with no stalls; oADDR SHALL hold 0 in IDLE.
REQ-017 The x/y coordinates of each issued address SHALL be carried through an RD_LAT-deep pipeline so that they align with iDATA.
REQ-018 A pixel SHALL be bright when iDATA > latched threshold (strictly greater); iDATA = threshold SHALL not qualify.
REQ-019 Running min/max accumulators SHALL initialise on the first bright pixel of a scan; later bright pixels SHALL widen the box only.
REQ-020 The accumulators SHALL clear on an accepted iSTART; the result outputs SHALL NOT change until DONE.
REQ-021 In DONE, the results SHALL be copied to the outputs and oDONE=1 for exactly that cycle; the outputs SHALL then hold until the next DONE.
REQ-022 For a frame with no bright pixel, the scan SHALL end with oVALID=0 and oXMIN/oXMAX/oYMIN/oYMAX=0.
REQ-023 A full scan SHALL take WIDTH*HEIGHT+RD_LAT+1 cycles from iSTART to oDONE, which is 76803 at the defaults.
REQ-024 An iSTART arriving in the DONE cycle SHALL be ignored; an iSTART arriving in IDLE on the cycle after DONE SHALL be accepted.
REQ-025 Coordinate counters SHALL wrap x at WIDTH-1 to 0 and increment y; no arithmetic SHALL overflow its declared width.

Reset
REQ-026 Asserting iRESET SHALL force IDLE and drive oADDR=0, oBUSY=0, oDONE=0, oVALID=0, all bbox outputs 0, and the internal pipeline and accumulators to 0.
REQ-027 Reset asserted mid-scan SHALL abort the scan without any oDONE pulse; the next iSTART after release SHALL begin a clean scan from address 0.

Configuration
REQ-028 With macro LIGHT_BBOX_COUNT_EN defined, the block SHALL add output oCOUNT (17 bits, the number of bright pixels, saturating at 76800) and parameter MIN_PIXELS (default 4), and oVALID SHALL equal (count >= MIN_PIXELS), with the bbox outputs forced to 0 when oVALID=0.
REQ-029 Without LIGHT_BBOX_COUNT_EN, oCOUNT and MIN_PIXELS SHALL be absent and oVALID SHALL equal (count > 0), tracked by a 1-bit flag.

Verification
REQ-030 All-zero frame with threshold 10 -> oDONE exactly 76803 cycles after iSTART, with oVALID=0 and all bbox outputs 0.
REQ-031 A single pixel 200 at (x=17, y=33) with threshold 100 -> oXMIN=oXMAX=17 and oYMIN=oYMAX=33, with oVALID=1 (oCOUNT=1 and oVALID=0 when COUNT_EN is defined with MIN_PIXELS=4).
REQ-032 Pixels 255 at (0,0) and (319,239), with threshold 254 -> box 0..319 by 0..239; a pixel equal to 254 elsewhere -> not counted.
REQ-033 iRESET pulsed at address 40000 -> no oDONE, all outputs 0; a subsequent full scan -> correct results and oADDR restarting at 0.
REQ-034 iSTART held high throughout a scan -> exactly one scan, one oDONE, and a new scan accepted only from IDLE.
REQ-035 RD_LAT=1 and RD_LAT=4 with the REQ-031 image -> identical coordinates, with oDONE latency 76802 and 76805 respectively.
